// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding, idle-access constants and depth helper
package sram_ctrl_pkg;
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam logic WEN_IDLE = 1'b1;
  localparam logic OEN_IDLE = 1'b1;
  function automatic int mem_depth(input int aw);
    return 2 ** aw;
  endfunction
endpackage

// File: rtl/sram_ctrl_fifo.sv
// sync_fifo: synchronous FIFO with occupancy count, used as the read response buffer
module sync_fifo #(
  parameter int DATA_BW   = 64,
  parameter int RSP_DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [DATA_BW-1:0]             i_data,
  output logic [DATA_BW-1:0]             o_data,
  output logic [$clog2(RSP_DEPTH):0]     o_count
);
  localparam int AW = $clog2(RSP_DEPTH);

  logic [DATA_BW-1:0] r_mem [RSP_DEPTH];
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [AW:0]        r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(i_push);
      r_rptr  <= r_rptr + AW'(i_pop);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(i_push && !i_pop && r_count == (AW+1)'(RSP_DEPTH)));
endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: zero-fills the SRAM after reset, then serves in-order read/write requests with credit-protected responses
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_BW   = 6,
  parameter int DATA_BW   = 64,
  parameter int RSP_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [ADDR_BW-1:0] i_req_addr,
  input  logic [DATA_BW-1:0] i_req_wdata,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [DATA_BW-1:0] o_rsp_data,
  output logic [ADDR_BW-1:0] o_mem_addr,
  output logic [DATA_BW-1:0] o_mem_wdata,
  output logic               o_mem_wen,
  output logic               o_mem_oen,
  input  logic [DATA_BW-1:0] i_mem_rdata,
  output logic               o_init_done
);
  localparam int MEM_DEPTH = mem_depth(ADDR_BW);
  localparam int CW        = $clog2(RSP_DEPTH) + 1;

  state_t           r_state, w_state_nxt;
  logic [ADDR_BW:0] r_clr_cnt;
  logic             r_inflight;
  logic             w_accept;
  logic [CW-1:0]    w_count;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state    <= ST_CLEAR;
      r_clr_cnt  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_cnt  <= r_clr_cnt + (ADDR_BW+1)'(r_state == ST_CLEAR);
      r_inflight <= w_accept && !i_req_we;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wen   = WEN_IDLE;
    o_mem_oen   = OEN_IDLE;
    if (i_rstn && r_state == ST_CLEAR) begin
      o_mem_addr  = r_clr_cnt[ADDR_BW-1:0];
      o_mem_wen   = 1'b0;
      w_state_nxt = (r_clr_cnt == (ADDR_BW+1)'(MEM_DEPTH - 1)) ? ST_RUN : ST_CLEAR;
    end else if (i_rstn && i_req_valid && o_req_ready) begin
      w_accept    = 1'b1;
      o_mem_addr  = i_req_addr;
      o_mem_wdata = i_req_we ? i_req_wdata : '0;
      o_mem_wen   = !i_req_we;
      o_mem_oen   = i_req_we;
    end
  end

  assign o_req_ready = (r_state == ST_RUN) &&
                       ({1'b0, w_count} + (CW+1)'(r_inflight) < (CW+1)'(RSP_DEPTH));
  assign o_init_done = (r_state == ST_RUN);
  assign o_rsp_valid = (w_count != '0);

  sync_fifo #(.DATA_BW(DATA_BW), .RSP_DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (r_inflight),
    .i_pop   (o_rsp_valid && i_rsp_ready),
    .i_data  (i_mem_rdata),
    .o_data  (o_rsp_data),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized self-checking bench with an SRAM model and a transaction-level reference
module tb_sram_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_req_valid, i_req_we, i_rsp_ready;
  logic [5:0]  i_req_addr;
  logic [63:0] i_req_wdata;
  logic        o_req_ready, o_rsp_valid, o_mem_wen, o_mem_oen, o_init_done;
  logic [63:0] o_rsp_data, o_mem_wdata, i_mem_rdata;
  logic [5:0]  o_mem_addr;

  typedef struct {logic [63:0] d; int due;} rsp_t;

  logic [63:0] sram [64];
  logic [63:0] ref_mem [64];
  rsp_t        q[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 i_clk = ~i_clk;

  sram_ctrl dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wen(o_mem_wen), .o_mem_oen(o_mem_oen),
    .i_mem_rdata(i_mem_rdata), .o_init_done(o_init_done)
  );

  initial for (int i = 0; i < 64; i++) sram[i] = {$urandom, $urandom};

  always @(posedge i_clk) begin
    if (!o_mem_wen) sram[o_mem_addr] <= o_mem_wdata;
    if (!o_mem_oen) i_mem_rdata <= sram[o_mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [5:0] a, input logic [63:0] d,
                      input logic rr, output logic acc, output logic pop);
    i_req_valid = v; i_req_we = we; i_req_addr = a; i_req_wdata = d; i_rsp_ready = rr;
    #1;
    chk("ready", o_req_ready, q.size() < 4);
    chk("rsp_valid", o_rsp_valid, q.size() > 0 && q[0].due <= cyc);
    chk("en_excl", o_mem_wen | o_mem_oen, 1);
    acc = v && o_req_ready;
    pop = o_rsp_valid && rr && q.size() > 0;
    if (pop) begin
      chk("rsp_data", o_rsp_data, q[0].d);
      void'(q.pop_front());
    end
    if (acc) begin
      chk("acc_addr", o_mem_addr, a);
      chk("acc_wen", o_mem_wen, !we);
      chk("acc_oen", o_mem_oen, we);
      if (we) begin
        chk("acc_wdata", o_mem_wdata, d);
        ref_mem[a] = d;
      end else q.push_back('{ref_mem[a], cyc + 2});
    end else begin
      chk("idle_en", {o_mem_wen, o_mem_oen}, 2'b11);
      chk("idle_addr", o_mem_addr, 0);
      chk("idle_wdata", o_mem_wdata, 0);
    end
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic clear_seq();
    i_rstn = 1'b1; i_req_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      #1;
      chk("clr_wen", o_mem_wen, 0);
      chk("clr_oen", o_mem_oen, 1);
      chk("clr_addr", o_mem_addr, k);
      chk("clr_wdata", o_mem_wdata, 0);
      chk("clr_ready", o_req_ready, 0);
      chk("clr_done", o_init_done, 0);
      @(negedge i_clk);
    end
    #1;
    chk("init_done", o_init_done, 1);
    chk("init_ready", o_req_ready, 1);
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, pop;
    int n, np;
    i_rstn = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
    i_req_wdata = '0; i_rsp_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_done", o_init_done, 0);
    chk("rst_ready", o_req_ready, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_en", {o_mem_wen, o_mem_oen}, 2'b11);
    clear_seq();

    step(1, 0, 6'd37, 0, 1, acc, pop);
    repeat (3) step(0, 0, 0, 0, 1, acc, pop);

    step(1, 1, 6'd5, 64'hDEAD_BEEF_0123_4567, 1, acc, pop);
    step(1, 0, 6'd5, 0, 1, acc, pop);
    repeat (3) step(0, 0, 0, 0, 1, acc, pop);

    for (int a = 0; a < 8; a++) begin
      step(1, 0, 6'(a), 0, 1, acc, pop);
      chk("t3_accept", acc, 1);
    end
    repeat (3) step(0, 0, 0, 0, 1, acc, pop);

    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 6'($urandom_range(63)), 0, 0, acc, pop);
      n += int'(acc);
    end
    chk("t4_accepts", n, 4);
    np = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, acc, pop);
      np += int'(pop);
    end
    chk("t4_drained", np, 4);
    step(1, 0, 6'd9, 0, 1, acc, pop);
    chk("t4_resume", acc, 1);
    repeat (3) step(0, 0, 0, 0, 1, acc, pop);

    for (int i = 0; i < 12; i++) begin
      step(1, 0, 6'($urandom_range(63)), 0, 1, acc, pop);
      chk("t5_accept", acc, 1);
      if (i >= 3) chk("t5_pop", pop, 1);
    end
    repeat (3) step(0, 0, 0, 0, 1, acc, pop);

    for (int i = 0; i < 400; i++)
      step($urandom_range(9) < 7, $urandom_range(1), 6'($urandom_range(7)),
           {$urandom, $urandom}, $urandom_range(9) < 6, acc, pop);
    repeat (6) step(0, 0, 0, 0, 1, acc, pop);

    step(1, 1, 6'd3, 64'h1234_5678_9ABC_DEF0, 0, acc, pop);
    for (int a = 0; a < 3; a++) step(1, 0, 6'(a + 3), 0, 0, acc, pop);
    chk("t6_pending", q.size() >= 2, 1);
    i_req_valid = 1'b0; i_rstn = 1'b0;
    @(negedge i_clk);
    #1;
    chk("t6_rsp_valid", o_rsp_valid, 0);
    chk("t6_done", o_init_done, 0);
    chk("t6_ready", o_req_ready, 0);
    q.delete();
    clear_seq();
    for (int a = 0; a < 4; a++) step(1, 0, 6'(a + 3), 0, 1, acc, pop);
    repeat (4) step(0, 0, 0, 0, 1, acc, pop);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
